// File: rtl/piano_pkg.sv
// Shared constants for the piano datapath: rest/idle words, the octave-1
// note table and octave limits. Also imported by the recorder and tone
// generator, so encodings stay consistent across blocks.
package piano_pkg;

  // Word recorded/emitted when no key is held.
  localparam logic [31:0] REST_FREQ   = 32'd20000;
  // Word the tone generator treats as "play nothing".
  localparam logic [31:0] SILENT_FREQ = 32'd100_000_000;

  localparam int NOTE_COUNT = 8;

  // C4..C5 at octave 1, in Hz.
  localparam logic [15:0] BASE_NOTE_HZ [NOTE_COUNT] = '{
    16'd262, 16'd294, 16'd330, 16'd349, 16'd392, 16'd440, 16'd494, 16'd523
  };

  typedef logic [1:0] octave_t;

  localparam octave_t OCT_MIN     = 2'd0;
  localparam octave_t OCT_MAX     = 2'd2;
  localparam octave_t OCT_DEFAULT = 2'd1;

  typedef enum logic [1:0] {
    OCT_HOLD,
    OCT_STEP_UP,
    OCT_STEP_DOWN
  } oct_step_e;

  // Scale an octave-1 frequency to the requested octave (0: halve, truncating;
  // 2: double), zero-extended to the 32-bit freq word.
  function automatic logic [31:0] scale_note(input logic [15:0] base_hz,
                                             input octave_t     oct);
    logic [31:0] wide;
    wide = {16'd0, base_hz};
    case (oct)
      2'd0:    return wide >> 1;
      2'd2:    return wide << 1;
      default: return wide;
    endcase
  endfunction

endpackage

// File: rtl/key_freq_encoder_if.sv
// Switch inputs and note outputs of the key/frequency front end.
interface key_freq_encoder_if
  import piano_pkg::*;
#(
  parameter int NUM_KEYS = 8
);

  logic [NUM_KEYS-1:0] keys;
  logic                oct_up;
  logic                oct_down;
  logic [31:0]         freq;
  logic                key_valid;
  logic [3:0]          key_code;
  octave_t             octave;
  logic                note_change;

  // Drives the buttons, observes the note.
  modport master (
    output keys, oct_up, oct_down,
    input  freq, key_valid, key_code, octave, note_change
  );

  // The encoder itself.
  modport slave (
    input  keys, oct_up, oct_down,
    output freq, key_valid, key_code, octave, note_change
  );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability counter: the output only
// follows the input after it has differed from it for DEBOUNCE_CYCLES
// consecutive clocks; any shorter excursion is forgotten.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous switch into the clock domain.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw_i};
  end

  // Count consecutive disagreeing cycles; flip once the run is long enough.
  // NOTE: every output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stable bit and run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_freq_encoder.sv
// Debounces the note keys and octave buttons, picks the lowest held key and
// registers its frequency at the current octave (or the rest word).
module key_freq_encoder #(
  parameter int          NUM_KEYS        = 8,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] REST_FREQ       = piano_pkg::REST_FREQ
) (
  input logic               clk,
  input logic               reset,
  key_freq_encoder_if.slave bus
);

  import piano_pkg::*;

  logic [NUM_KEYS-1:0] key_db;
  logic                up_db, dn_db;
  logic                up_prev_q, dn_prev_q;
  oct_step_e           oct_step;
  octave_t             octave_q, octave_d;

  logic                hit;
  logic [3:0]          code_sel;
  logic [15:0]         base_hz;
  logic [31:0]         freq_q, freq_d;
  logic                key_valid_q, key_valid_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                note_change_q, note_change_d;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_db
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (bus.keys[gi]),
      .stable_o (key_db[gi])
    );
  end

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus.oct_up),
    .stable_o (up_db)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus.oct_down),
    .stable_o (dn_db)
  );

  // Remember last debounced button levels for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      up_prev_q <= up_db;
      dn_prev_q <= dn_db;
    end
  end

  // Decide the octave step; both edges together cancel, limits saturate.
  always_comb begin
    logic up_rise, dn_rise;
    up_rise  = up_db & ~up_prev_q;
    dn_rise  = dn_db & ~dn_prev_q;
    oct_step = OCT_HOLD;
    if (up_rise && !dn_rise)      oct_step = OCT_STEP_UP;
    else if (dn_rise && !up_rise) oct_step = OCT_STEP_DOWN;

    octave_d = octave_q;
    case (oct_step)
      OCT_STEP_UP:   if (octave_q != OCT_MAX) octave_d = octave_q + 2'd1;
      OCT_STEP_DOWN: if (octave_q != OCT_MIN) octave_d = octave_q - 2'd1;
      default:       ;
    endcase
  end

  // Octave register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) octave_q <= OCT_DEFAULT;
    else       octave_q <= octave_d;
  end

  // Lowest-index held key wins; scanning downward lets it overwrite others.
  always_comb begin
    hit      = 1'b0;
    code_sel = 4'd0;
    base_hz  = 16'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_db[i]) begin
        hit      = 1'b1;
        code_sel = 4'(i);
        base_hz  = BASE_NOTE_HZ[i];
      end
    end
    freq_d        = hit ? scale_note(base_hz, octave_q) : REST_FREQ;
    key_valid_d   = hit;
    key_code_d    = code_sel;
    note_change_d = (freq_d != freq_q);
  end

  // Registered outputs; note_change rises with the first cycle of a new freq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_q        <= REST_FREQ;
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'd0;
      note_change_q <= 1'b0;
    end else begin
      freq_q        <= freq_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      note_change_q <= note_change_d;
    end
  end

  assign bus.freq        = freq_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.octave      = octave_q;
  assign bus.note_change = note_change_q;

endmodule
